// File: rtl/fetch_stage_8085.sv
// Instruction-fetch front end for the 8085 pipeline.
// Holds the fetch PC and issues one byte read per cycle to a synchronous ROM.
// Returned bytes are queued with their addresses in a small prefetch FIFO.
// Decode consumes from the FIFO with valid/ready. A redirect flushes everything
// and restarts fetch at the new address.
module fetch_stage_8085 #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDR_W-1:0]        imem_addr,
    output logic                     imem_rd,
    input  logic [DATA_W-1:0]        imem_data,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [DATA_W-1:0]        instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [ADDR_W-1:0]        pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Occupancy is count plus the single in-flight read, so it needs one extra bit.
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [CNT_W:0]    occ;
    logic              issue;
    logic              push;
    logic              pop;

    // Issue/push/pop decisions. Redirect overrides everything: no issue, the
    // returning byte is dropped and the head is not consumed. The reset term is
    // applied only on the external strobe; the flops are held by the async reset.
    always_comb begin
        occ   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
        issue = ~redirect & (occ < DEPTH_OCC);
        push  = inflight_q & ~redirect;
        pop   = (cnt_q != '0) & instr_ready & ~redirect;
    end

    // Next-state for PC, the return-address pipeline and the FIFO bookkeeping.
    always_comb begin
        pc_d       = pc_q;
        addr_d     = addr_q;
        inflight_d = issue;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        if (redirect) begin
            pc_d  = redirect_pc;
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (issue) begin
                pc_d   = pc_q + ADDR_W'(1);
                addr_d = pc_q;
            end
            if (push) wr_d = wr_q + PTR_W'(1);
            if (pop)  rd_d = rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage: byte plus the address it was fetched from; no reset needed
    // because entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_q] <= imem_data;
            addr_mem[wr_q] <= addr_q;
        end
    end

    // Outputs; head fields are forced to zero while the FIFO is empty.
    always_comb begin
        imem_addr   = pc_q;
        imem_rd     = issue & rst_n;
        instr_valid = (cnt_q != '0);
        instr       = instr_valid ? data_mem[rd_q] : '0;
        instr_pc    = instr_valid ? addr_mem[rd_q] : '0;
        pc          = pc_q;
        q_count     = cnt_q;
    end

endmodule
